// File: rtl/kf6845_fetch_pkg.sv
// Shared types and constants for the KF6845 character fetch path.
package kf6845_fetch_pkg;

  localparam int MA_WIDTH        = 14;
  localparam int RA_WIDTH        = 5;
  localparam int VRAM_DATA_WIDTH = 16;

  localparam logic [7:0] BLANK_PIXEL = 8'h00;
  localparam logic [7:0] BLANK_ATTR  = 8'h00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VRAM_REQ  = 2'd1,
    FONT_WAIT = 2'd2,
    DONE      = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [MA_WIDTH-1:0] ma;
    logic [RA_WIDTH-1:0] ra;
    logic                de;
    logic                cursor;
  } fetch_slot_t;

  typedef struct packed {
    logic [7:0] pixel;
    logic [7:0] attr;
  } cell_t;

  localparam cell_t BLANK_CELL = '{pixel: BLANK_PIXEL, attr: BLANK_ATTR};

endpackage

// File: rtl/kf6845_character_fetch_if.sv
// VRAM read port and font ROM port of the character fetch unit.
interface kf6845_character_fetch_if #(
  parameter int FONT_ROW_BITS = 4
) ();

  logic                                          vram_read_req;
  logic [kf6845_fetch_pkg::MA_WIDTH-1:0]         vram_address;
  logic                                          vram_ack;
  logic [kf6845_fetch_pkg::VRAM_DATA_WIDTH-1:0]  vram_read_data;
  logic [7+FONT_ROW_BITS:0]                      font_address;
  logic [7:0]                                    font_data;

  modport master (
    output vram_read_req, vram_address, font_address,
    input  vram_ack, vram_read_data, font_data
  );

  modport slave (
    input  vram_read_req, vram_address, font_address,
    output vram_ack, vram_read_data, font_data
  );

endinterface

// File: rtl/kf6845_fetch_sequencer.sv
// Fetch FSM: VRAM request/ack, font lookup, and discard/pending handling on underrun.
module kf6845_fetch_sequencer
  import kf6845_fetch_pkg::*;
#(
  parameter int FONT_ROW_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_i,
  input  fetch_slot_t sample_i,
  input  fetch_slot_t slot_i,
  kf6845_character_fetch_if.master bus,
  output logic        busy_o,
  output cell_t       result_o,
  output logic        fetch_underrun_o
);

  fetch_state_t             state_q;
  logic                     pending_q;
  logic                     discard_q;
  logic                     req_q;
  logic                     underrun_q;
  logic [MA_WIDTH-1:0]      addr_q;
  logic [FONT_ROW_BITS-1:0] row_q;
  logic [7:0]               attr_q;
  logic [7+FONT_ROW_BITS:0] font_addr_q;
  cell_t                    result_q;

  logic        busy_d;
  logic        launch_d;
  fetch_slot_t launch_slot_d;

  // slot_i always holds the newest sample, so it doubles as the pending entry.
  always_comb begin
    busy_d        = (state_q == VRAM_REQ) || (state_q == FONT_WAIT);
    launch_d      = 1'b0;
    launch_slot_d = sample_i;
    case (state_q)
      IDLE, DONE: launch_d = enable_i;
      FONT_WAIT: begin
        if (enable_i) begin
          launch_d = 1'b1;
        end else if (pending_q) begin
          launch_d      = 1'b1;
          launch_slot_d = slot_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      discard_q   <= 1'b0;
      req_q       <= 1'b0;
      underrun_q  <= 1'b0;
      addr_q      <= '0;
      row_q       <= '0;
      attr_q      <= '0;
      font_addr_q <= '0;
      result_q    <= BLANK_CELL;
    end else begin
      underrun_q <= enable_i && busy_d;
      case (state_q)
        VRAM_REQ: begin
          if (enable_i) begin
            pending_q <= 1'b1;
            discard_q <= 1'b1;
          end
          if (bus.vram_ack) begin
            req_q       <= 1'b0;
            attr_q      <= bus.vram_read_data[VRAM_DATA_WIDTH-1:8];
            font_addr_q <= {bus.vram_read_data[7:0], row_q};
            state_q     <= FONT_WAIT;
          end
        end
        FONT_WAIT: begin
          if (!discard_q && !enable_i) begin
            result_q <= '{pixel: bus.font_data, attr: attr_q};
            state_q  <= DONE;
          end
        end
        default: ;
      endcase
      // A launch overrides whatever the case above decided for state.
      if (launch_d) begin
        pending_q <= 1'b0;
        discard_q <= 1'b0;
        if (launch_slot_d.de) begin
          state_q <= VRAM_REQ;
          req_q   <= 1'b1;
          addr_q  <= launch_slot_d.ma;
          row_q   <= launch_slot_d.ra[FONT_ROW_BITS-1:0];
        end else begin
          state_q  <= DONE;
          result_q <= BLANK_CELL;
        end
      end
    end
  end

  assign bus.vram_read_req = req_q;
  assign bus.vram_address  = addr_q;
  assign bus.font_address  = font_addr_q;
  assign busy_o            = busy_d;
  assign result_o          = result_q;
  assign fetch_underrun_o  = underrun_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, sample_i.cursor, slot_i.cursor,
                         sample_i.ra, slot_i.ra};

endmodule

// File: rtl/kf6845_character_fetch.sv
// Character fetch top: sample slot, one-character-clock output stage, DE/cursor delay.
module kf6845_character_fetch
  import kf6845_fetch_pkg::*;
#(
  parameter int FONT_ROW_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                video_clock_enable,
  input  logic [MA_WIDTH-1:0] MA,
  input  logic [RA_WIDTH-1:0] RA,
  input  logic                DE,
  input  logic                cursor,
  kf6845_character_fetch_if.master bus,
  output logic [7:0]          pixel_data,
  output logic [7:0]          attribute_data,
  output logic                display_enable_out,
  output logic                cursor_out,
  output logic                fetch_underrun
);

  fetch_slot_t sample_d;
  fetch_slot_t slot_q;
  cell_t       cell_q;
  cell_t       result;
  logic        disp_q;
  logic        cur_q;
  logic        busy;

  assign sample_d = '{ma: MA, ra: RA, de: DE, cursor: cursor};

  kf6845_fetch_sequencer #(
    .FONT_ROW_BITS (FONT_ROW_BITS)
  ) u_sequencer (
    .clock            (clock),
    .reset            (reset),
    .enable_i         (video_clock_enable),
    .sample_i         (sample_d),
    .slot_i           (slot_q),
    .bus              (bus),
    .busy_o           (busy),
    .result_o         (result),
    .fetch_underrun_o (fetch_underrun)
  );

  // A fetch still in flight at the boundary shows as a blank cell.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
      cell_q <= BLANK_CELL;
      disp_q <= 1'b0;
      cur_q  <= 1'b0;
    end else if (video_clock_enable) begin
      slot_q <= sample_d;
      cell_q <= busy ? BLANK_CELL : result;
      disp_q <= slot_q.de;
      cur_q  <= slot_q.cursor;
    end
  end

  assign pixel_data         = cell_q.pixel;
  assign attribute_data     = cell_q.attr;
  assign display_enable_out = disp_q;
  assign cursor_out         = cur_q;

endmodule

// File: tb/tb_kf6845_character_fetch.sv
// Directed bench for kf6845_character_fetch with behavioural VRAM and font ROM.
module tb_kf6845_character_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        video_clock_enable = 1'b0;
  logic [13:0] MA = '0;
  logic [4:0]  RA = '0;
  logic        DE = 1'b0;
  logic        cursor = 1'b0;
  logic [7:0]  pixel_data;
  logic [7:0]  attribute_data;
  logic        display_enable_out;
  logic        cursor_out;
  logic        fetch_underrun;

  int checks = 0;
  int errors = 0;
  int vram_wait = 2;
  int cur_wait = 0;
  int wait_cnt = 0;
  bit active = 1'b0;
  int underrun_pulses = 0;

  kf6845_character_fetch_if #(.FONT_ROW_BITS(4)) vbus ();

  kf6845_character_fetch #(.FONT_ROW_BITS(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .video_clock_enable (video_clock_enable),
    .MA                 (MA),
    .RA                 (RA),
    .DE                 (DE),
    .cursor             (cursor),
    .bus                (vbus),
    .pixel_data         (pixel_data),
    .attribute_data     (attribute_data),
    .display_enable_out (display_enable_out),
    .cursor_out         (cursor_out),
    .fetch_underrun     (fetch_underrun)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] vram_word(input logic [13:0] a);
    if (a == 14'h0123) return 16'h1E41;
    return {a[7:0], ~a[7:0]};
  endfunction

  function automatic logic [7:0] font_row(input logic [11:0] a);
    if (a == 12'h413) return 8'h3C;
    return ~a[7:0];
  endfunction

  // VRAM: wait count is fixed when a request is first seen, then ack for one cycle.
  initial begin
    vbus.vram_ack = 1'b0;
    vbus.vram_read_data = '0;
    vbus.font_data = '0;
  end

  always @(posedge clock) begin
    #1;
    if (!reset) begin
      vbus.vram_ack = 1'b0;
      active = 1'b0;
      wait_cnt = 0;
    end else if (vbus.vram_ack) begin
      vbus.vram_ack = 1'b0;
      active = 1'b0;
    end else if (vbus.vram_read_req) begin
      if (!active) begin
        active = 1'b1;
        wait_cnt = 0;
        cur_wait = vram_wait;
      end
      if (wait_cnt >= cur_wait) begin
        vbus.vram_ack = 1'b1;
        vbus.vram_read_data = vram_word(vbus.vram_address);
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    vbus.font_data = font_row(vbus.font_address);
    if (fetch_underrun) underrun_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic enable_cell(input logic [13:0] ma, input logic [4:0] ra,
                             input logic de, input logic cur);
    MA = ma;
    RA = ra;
    DE = de;
    cursor = cur;
    video_clock_enable = 1'b1;
    tick();
    video_clock_enable = 1'b0;
    $display("cell ma=%04h ra=%02h de=%0b cur=%0b -> pix=%02h attr=%02h de_out=%0b cur_out=%0b urun=%0b",
             ma, ra, de, cur, pixel_data, attribute_data, display_enable_out, cursor_out, fetch_underrun);
  endtask

  bit saw_req;

  initial begin
    #2 reset = 1'b0;
    idle(2);
    check("rst_req", vbus.vram_read_req, 0);
    check("rst_pix", pixel_data, 0);
    check("rst_attr", attribute_data, 0);
    check("rst_de", display_enable_out, 0);
    check("rst_urun", fetch_underrun, 0);
    reset = 1'b1;
    idle(3);

    // normal cell
    vram_wait = 2;
    enable_cell(14'h0123, 5'd3, 1'b1, 1'b0);
    check("n_req", vbus.vram_read_req, 1);
    check("n_addr", vbus.vram_address, 14'h0123);
    idle(4);
    check("n_font_addr", vbus.font_address, 12'h413);
    idle(3);
    // blank cell
    enable_cell(14'h0200, 5'd0, 1'b0, 1'b0);
    check("n_pix", pixel_data, 8'h3C);
    check("n_attr", attribute_data, 8'h1E);
    check("n_de", display_enable_out, 1);
    check("n_urun", fetch_underrun, 0);
    saw_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      saw_req |= vbus.vram_read_req;
      tick();
    end
    check("b_noreq", saw_req, 0);
    // cursor cell at top address
    enable_cell(14'h3FFF, 5'd5, 1'b1, 1'b1);
    check("b_pix", pixel_data, 8'h00);
    check("b_attr", attribute_data, 8'h00);
    check("b_de", display_enable_out, 0);
    idle(7);
    enable_cell(14'h0010, 5'd0, 1'b1, 1'b0);
    check("c_pix", pixel_data, 8'hFA);
    check("c_attr", attribute_data, 8'hFF);
    check("c_de", display_enable_out, 1);
    check("c_cur", cursor_out, 1);
    idle(7);

    // underrun: slow ack
    vram_wait = 10;
    enable_cell(14'h0456, 5'd1, 1'b1, 1'b0);
    check("c2_pix", pixel_data, 8'h0F);
    check("c2_attr", attribute_data, 8'h10);
    check("c2_cur", cursor_out, 0);
    idle(7);
    check("u_req_hold", vbus.vram_read_req, 1);
    enable_cell(14'h0789, 5'd2, 1'b1, 1'b0);
    vram_wait = 0;
    check("u_pulse", fetch_underrun, 1);
    check("u_pix", pixel_data, 8'h00);
    check("u_attr", attribute_data, 8'h00);
    check("u_de", display_enable_out, 1);
    check("u_req", vbus.vram_read_req, 1);
    check("u_addr_hold", vbus.vram_address, 14'h0456);
    tick();
    check("u_pulse_end", fetch_underrun, 0);
    idle(3);
    check("u_pend_req", vbus.vram_read_req, 1);
    check("u_pend_addr", vbus.vram_address, 14'h0789);
    idle(3);

    // ack lands on the same cycle as the enable
    vram_wait = 7;
    enable_cell(14'h0ABC, 5'd4, 1'b1, 1'b0);
    check("p_pix", pixel_data, 8'h9D);
    check("p_attr", attribute_data, 8'h89);
    check("p_urun", fetch_underrun, 0);
    idle(7);
    enable_cell(14'h0DEF, 5'h16, 1'b1, 1'b1);
    vram_wait = 0;
    check("k_pulse", fetch_underrun, 1);
    check("k_pix", pixel_data, 8'h00);
    check("k_req", vbus.vram_read_req, 0);
    check("k_font_addr", vbus.font_address, 12'h434);
    tick();
    check("k_pend_req", vbus.vram_read_req, 1);
    check("k_pend_addr", vbus.vram_address, 14'h0DEF);
    idle(6);
    vram_wait = 5;
    enable_cell(14'h0111, 5'd0, 1'b1, 1'b0);
    check("k2_pix", pixel_data, 8'hF9);
    check("k2_attr", attribute_data, 8'hEF);
    check("k2_de", display_enable_out, 1);
    check("k2_cur", cursor_out, 1);
    check("urun_pulses", underrun_pulses, 2);

    // reset in the middle of a VRAM request
    tick();
    check("r_req_before", vbus.vram_read_req, 1);
    reset = 1'b0;
    #1;
    check("r_req", vbus.vram_read_req, 0);
    check("r_addr", vbus.vram_address, 0);
    check("r_font_addr", vbus.font_address, 0);
    check("r_pix", pixel_data, 0);
    check("r_attr", attribute_data, 0);
    check("r_de", display_enable_out, 0);
    check("r_cur", cursor_out, 0);
    idle(2);
    reset = 1'b1;
    idle(3);
    check("r_idle_req", vbus.vram_read_req, 0);
    check("r_idle_urun", fetch_underrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
